mem_dump_unit: RTL
==================

// Module: mem_dump_unit
// PURPOSE
//  Hardware readback engine that drains processor state after a program run.
//  It is the reader-side counterpart of the program/memory loader.
//  On a start pulse it streams r0..r15, then every 32-bit word of the byte-wide
//  data memory, out on a valid/ready port. Bytes are packed little-endian: byte i
//  of a word sits at address word_addr+i. A host or bench writes the stream to an
//  "Updated_data"-style dump.
// PARAMETERS
//  ADDR_W    12       byte address width; memory is 2**ADDR_W bytes (0x1000)
//  NREG      16       number of architectural registers dumped
//  REG_W     32       register/word width; memory word = REG_W/8 bytes (fixed 4)
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  reset        in   1       synchronous, active-high reset
//  start        in   1       one-cycle request; honoured only in IDLE
//  busy         out  1       high from first cycle after accepted start until DONE
//  done         out  1       one-cycle pulse after last word handshakes
//  reg_rd_idx   out  4       register file read index (combinational read port)
//  reg_rd_data  in   REG_W   register value for reg_rd_idx, same cycle
//  mem_rd_en    out  1       byte read strobe to data memory
//  mem_rd_addr  out  ADDR_W  byte address of read
//  mem_rd_data  in   8       read data, valid exactly 1 cycle after mem_rd_en
//  out_valid    out  1       stream word valid
//  out_ready    in   1       sink accepts word when out_valid&&out_ready
//  out_data     out  REG_W   register value or assembled memory word
//  out_addr     out  ADDR_W  register index (zero-ext) or word byte address
//  out_is_reg   out  1       1 = register record, 0 = memory record
// BEHAVIOUR
//  Reset: state IDLE; busy, done, mem_rd_en, out_valid, out_is_reg = 0;
//   out_data, out_addr, mem_rd_addr, reg_rd_idx = 0. Reset mid-dump aborts
//   immediately to IDLE with no done pulse. reset wins over a coincident start.
//  FSM: IDLE -> REG_RD -> REG_OUT -> (REG_RD | MEM_RD) -> MEM_WAIT -> MEM_OUT
//   -> (MEM_RD | DONE) -> IDLE.
//  IDLE: start=1 clears counters, next REG_RD; start in other states ignored.
//  REG_RD (1 cyc): reg_rd_idx=ridx; capture reg_rd_data into out_data.
//  REG_OUT: out_valid=1, out_is_reg=1, out_addr=ridx. Hold all out_* stable
//   while !out_ready. On handshake: ridx==NREG-1 -> MEM_RD at waddr=0,
//   else ridx+1 -> REG_RD.
//  MEM_RD (4 cyc): mem_rd_en=1, mem_rd_addr=waddr+k, k=0..3. Each cycle k>0
//   captures the returned byte k-1 into byte lane k-1.
//  MEM_WAIT (1 cyc): mem_rd_en=0; capture byte 3.
//   Word = {b3,b2,b1,b0}.
//  MEM_OUT: out_valid=1, out_is_reg=0, out_addr=waddr; same hold rule.
//   On handshake: waddr==2**ADDR_W-4 -> DONE (no wrap to 0), else waddr+4 -> MEM_RD.
//  DONE (1 cyc): done=1, busy=0, next IDLE.
//  No memory reads are issued while stalled in MEM_OUT. Memory is read-only from
//   this block. Address arithmetic is ADDR_W bits. The terminal compare is made
//   before the increment.
//  Latency with out_ready=1: 2 cyc/register, 6 cyc/word. With start sampled in
//   cycle 0, done is high in cycle 1+2*NREG+6*2**(ADDR_W-2) = 6177 (defaults).
// STRUCTURE
//  mem_dump_pkg: state enum (IDLE, REG_RD, REG_OUT, MEM_RD, MEM_WAIT,
//   MEM_OUT, DONE), MEM_BYTES=4096, WORD_BYTES=4, LAST_WADDR=MEM_BYTES-4.
//  Sub-module byte_word_assembler: clear, load(lane 0..3, byte)
//   -> 32-bit word. The FSM, counters and output register stay in the top.
// TESTING
//  1 Reset: reset=1 for 3 cycles mid-dump (waddr=0x100) -> IDLE next cycle,
//    all outputs 0, no done; a later start restarts from r0.
//  2 Full drain, out_ready=1: r[i]=0xA0000000+i, mem[a]=a[7:0] -> 16 reg records,
//    then word@0x000=0x03020100, word@0xFFC=0xFFFEFDFC; done in cycle 6177.
//  3 Backpressure: drop out_ready for 5 cycles during r3 and word 0x010 -> out_*
//    stable, mem_rd_en=0 during stall, no record lost or duplicated.
//  4 Start while busy: pulse start during MEM_RD -> ignored; exactly 16+1024
//    records and one done pulse.
//  5 End boundary: after the 0xFFC handshake -> DONE then IDLE; mem_rd_addr
//    never exceeds 0xFFF and never returns to 0x000.
//  6 Back-to-back: start in the cycle after done -> second full identical dump.

Source files
------------

// File: rtl/mem_dump_pkg.sv
// Shared types and constants for the post-run state dump engine.
package mem_dump_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REG_RD   = 3'd1,
        REG_OUT  = 3'd2,
        MEM_RD   = 3'd3,
        MEM_WAIT = 3'd4,
        MEM_OUT  = 3'd5,
        DONE     = 3'd6
    } dump_state_e;

    localparam int MEM_BYTES  = 4096;
    localparam int WORD_BYTES = 4;
    localparam int LAST_WADDR = MEM_BYTES - WORD_BYTES;

endpackage

// File: rtl/byte_word_assembler.sv
// Collects four little-endian bytes into a 32-bit word; the output already
// reflects a byte being loaded this cycle so the caller can register it at once.
module byte_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_load,
    input  logic [1:0]  i_lane,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word
);

    logic [3:0][7:0] r_lanes;
    logic [3:0][7:0] w_word;

    // Lane storage, one byte per load
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lanes <= {4{8'h00}};
        end else if (i_clear) begin
            r_lanes <= {4{8'h00}};
        end else if (i_load) begin
            r_lanes[i_lane] <= i_byte;
        end else begin
            r_lanes <= r_lanes;
        end
    end

    // Stored lanes merged with the byte arriving this cycle
    always_comb begin
        w_word = r_lanes;
        if (i_load) begin
            w_word[i_lane] = i_byte;
        end else begin
            w_word = r_lanes;
        end
    end

    assign o_word = w_word;

endmodule

// File: rtl/mem_dump_unit.sv
// Readback engine: streams r0..r(NREG-1) then every memory word, little-endian,
// over a valid/ready port. All outputs are registered from the next-state decode.
module mem_dump_unit
    import mem_dump_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int NREG   = 16,
    parameter int REG_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [3:0]        reg_rd_idx,
    input  logic [REG_W-1:0]  reg_rd_data,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_W-1:0]  out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_is_reg
);

    localparam logic [ADDR_W-1:0] LAST_WADDR_A = ADDR_W'((2 ** ADDR_W) - WORD_BYTES);
    localparam logic [ADDR_W-1:0] WORD_STEP    = ADDR_W'(WORD_BYTES);
    localparam logic [3:0]        LAST_RIDX    = 4'(NREG - 1);

    dump_state_e       r_state;
    dump_state_e       w_state_nxt;
    logic [3:0]        r_ridx;
    logic [3:0]        w_ridx_nxt;
    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W-1:0] w_waddr_nxt;
    logic [1:0]        r_k;
    logic [1:0]        w_k_nxt;

    logic              w_asm_clear;
    logic              w_asm_load;
    logic [1:0]        w_asm_lane;
    logic [31:0]       w_asm_word;

    logic              r_busy;
    logic              r_done;
    logic              r_mem_rd_en;
    logic [ADDR_W-1:0] r_mem_rd_addr;
    logic              r_out_valid;
    logic              r_out_is_reg;
    logic [REG_W-1:0]  r_out_data;
    logic [ADDR_W-1:0] r_out_addr;

    byte_word_assembler u_asm (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_asm_clear),
        .i_load  (w_asm_load),
        .i_lane  (w_asm_lane),
        .i_byte  (mem_rd_data),
        .o_word  (w_asm_word)
    );

    // Next-state, counter and byte-capture decode
    always_comb begin
        w_state_nxt = r_state;
        w_ridx_nxt  = r_ridx;
        w_waddr_nxt = r_waddr;
        w_k_nxt     = r_k;
        w_asm_clear = 1'b0;
        w_asm_load  = 1'b0;
        w_asm_lane  = 2'd0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = REG_RD;
                    w_ridx_nxt  = 4'd0;
                    w_waddr_nxt = {ADDR_W{1'b0}};
                    w_k_nxt     = 2'd0;
                    w_asm_clear = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            REG_RD: begin
                w_state_nxt = REG_OUT;
            end
            REG_OUT: begin
                if (out_ready) begin
                    if (r_ridx == LAST_RIDX) begin
                        w_state_nxt = MEM_RD;
                        w_waddr_nxt = {ADDR_W{1'b0}};
                        w_k_nxt     = 2'd0;
                    end else begin
                        w_state_nxt = REG_RD;
                        w_ridx_nxt  = r_ridx + 4'd1;
                    end
                end else begin
                    w_state_nxt = REG_OUT;
                end
            end
            MEM_RD: begin
                // Data returns one cycle late, so slot k holds byte k-1
                w_asm_load = (r_k != 2'd0);
                w_asm_lane = r_k - 2'd1;
                if (r_k == 2'd3) begin
                    w_state_nxt = MEM_WAIT;
                end else begin
                    w_k_nxt = r_k + 2'd1;
                end
            end
            MEM_WAIT: begin
                w_asm_load  = 1'b1;
                w_asm_lane  = 2'd3;
                w_state_nxt = MEM_OUT;
            end
            MEM_OUT: begin
                if (out_ready) begin
                    if (r_waddr == LAST_WADDR_A) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = MEM_RD;
                        w_waddr_nxt = r_waddr + WORD_STEP;
                        w_k_nxt     = 2'd0;
                    end
                end else begin
                    w_state_nxt = MEM_OUT;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_ridx        <= 4'd0;
            r_waddr       <= {ADDR_W{1'b0}};
            r_k           <= 2'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_mem_rd_en   <= 1'b0;
            r_mem_rd_addr <= {ADDR_W{1'b0}};
            r_out_valid   <= 1'b0;
            r_out_is_reg  <= 1'b0;
            r_out_data    <= {REG_W{1'b0}};
            r_out_addr    <= {ADDR_W{1'b0}};
        end else begin
            r_state      <= w_state_nxt;
            r_ridx       <= w_ridx_nxt;
            r_waddr      <= w_waddr_nxt;
            r_k          <= w_k_nxt;
            r_busy       <= (w_state_nxt != IDLE) && (w_state_nxt != DONE);
            r_done       <= (w_state_nxt == DONE);
            r_mem_rd_en  <= (w_state_nxt == MEM_RD);
            r_out_valid  <= (w_state_nxt == REG_OUT) || (w_state_nxt == MEM_OUT);
            r_out_is_reg <= (w_state_nxt == REG_OUT);
            // Address holds its last value between bursts so it never wraps to 0
            if (w_state_nxt == MEM_RD) begin
                r_mem_rd_addr <= w_waddr_nxt + {{(ADDR_W-2){1'b0}}, w_k_nxt};
            end else begin
                r_mem_rd_addr <= r_mem_rd_addr;
            end
            case (w_state_nxt)
                REG_OUT: r_out_addr <= {{(ADDR_W-4){1'b0}}, w_ridx_nxt};
                MEM_OUT: r_out_addr <= w_waddr_nxt;
                default: r_out_addr <= r_out_addr;
            endcase
            case (r_state)
                REG_RD:   r_out_data <= reg_rd_data;
                MEM_WAIT: r_out_data <= REG_W'(w_asm_word);
                default:  r_out_data <= r_out_data;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign reg_rd_idx  = r_ridx;
    assign mem_rd_en   = r_mem_rd_en;
    assign mem_rd_addr = r_mem_rd_addr;
    assign out_valid   = r_out_valid;
    assign out_is_reg  = r_out_is_reg;
    assign out_data    = r_out_data;
    assign out_addr    = r_out_addr;

endmodule
